// File: rtl/cdc_bus_delay_rx_if.sv
// rtl/cdc_bus_delay_rx_if.sv - word stream, delay control and status bundle for cdc_bus_delay_rx
interface cdc_bus_delay_rx_if #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 4
);
    logic [FIFO_DATA_WIDTH-1:0] dinb;
    logic                       dinb_vld;
    logic [ADDR_WIDTH-1:0]      delay_cfg;
    logic                       flush;
    logic [FIFO_DATA_WIDTH-1:0] doutb;
    logic                       doutb_vld;
    logic [ADDR_WIDTH-1:0]      fill_lvl;

    modport master (
        output dinb, dinb_vld, delay_cfg, flush,
        input  doutb, doutb_vld, fill_lvl
    );

    modport slave (
        input  dinb, dinb_vld, delay_cfg, flush,
        output doutb, doutb_vld, fill_lvl
    );
endinterface

// File: rtl/cdc_bus_delay_rx.sv
// rtl/cdc_bus_delay_rx.sv - programmable sample delay on the clkb side of cdc_bus
module cdc_bus_delay_rx #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic               clkb,
    input  logic               rstb,
    cdc_bus_delay_rx_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0]      wr_ptr;
    logic [ADDR_WIDTH-1:0]      fill_cnt;
    logic [ADDR_WIDTH-1:0]      d_act;
    logic [FIFO_DATA_WIDTH-1:0] doutb_q;
    logic                       doutb_vld_q;

    logic [ADDR_WIDTH-1:0]      rd_addr;
    logic                       emit;

    // Read tap sits d_act samples behind the write pointer; an output is only
    // produced on a valid, non-flush sample once enough history is stored.
    always_comb begin
        rd_addr = wr_ptr - d_act;
        emit    = bus.dinb_vld && !bus.flush && (fill_cnt >= d_act);
    end

    // Sample storage; not reset, and the sample arriving during reset is dropped.
    always_ff @(posedge clkb) begin
        if (!rstb && bus.dinb_vld) begin
            mem[wr_ptr] <= bus.dinb;
        end
    end

    // Pointer, fill counter, delay register and output register.
    always_ff @(posedge clkb) begin
        if (rstb) begin
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            d_act       <= '0;
            doutb_q     <= '0;
            doutb_vld_q <= 1'b0;
        end else begin
            d_act       <= bus.delay_cfg;
            doutb_vld_q <= emit;
            if (bus.dinb_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (bus.flush) begin
                    fill_cnt <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end else if (fill_cnt != FILL_MAX) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end else if (bus.flush) begin
                fill_cnt <= '0;
            end
            // Zero delay bypasses the RAM so the word is not read before it is written.
            if (emit) begin
                doutb_q <= (d_act == '0) ? bus.dinb : mem[rd_addr];
            end
        end
    end

    assign bus.doutb     = doutb_q;
    assign bus.doutb_vld = doutb_vld_q;
    assign bus.fill_lvl  = fill_cnt;
endmodule

// File: doc/cdc_bus_delay_rx.md
Name: cdc_bus_delay_rx

Overview:
- Receive-side consumer of the cdc_bus word stream, running entirely in the clkb domain.
- Takes the words the async FIFO delivers (dinb plus a qualifying valid) and re-emits each valid word exactly D valid samples later, where D = delay_cfg.
- Storage is a circular buffer with a write pointer and a fill counter.
- Provides the programmable sample delay of the datapath_delay chain, with explicit output-valid qualification and a flush.

Parameters:
- FIFO_DATA_WIDTH, 32: width of dinb/doutb; must match the cdc_bus instance feeding this block.
- ADDR_WIDTH, 4: buffer address width; DEPTH = 2^ADDR_WIDTH (16); maximum delay is DEPTH-1.

Ports:
- clkb  input  1  single clock; all logic on rising edge.
- rstb  input  1  synchronous, active-high reset.
- dinb  input  FIFO_DATA_WIDTH  data word from cdc_bus doutb.
- dinb_vld  input  1  dinb carries a valid sample this cycle.
- delay_cfg  input  ADDR_WIDTH  requested delay D in samples, 0..DEPTH-1; quasi-static.
- flush  input  1  single-cycle pulse; discards all buffered history.
- doutb  output  FIFO_DATA_WIDTH  delayed sample.
- doutb_vld  output  1  doutb valid this cycle.
- fill_lvl  output  ADDR_WIDTH  stored-sample count, saturating at DEPTH-1.

Behaviour:
- Reset (rstb=1 at an edge):
  - wr_ptr=0, fill_cnt=0, d_act=0, doutb=0, doutb_vld=0, fill_lvl=0.
  - Buffer RAM is not reset.
  - Reset dominates flush and dinb_vld in the same cycle; that sample is dropped.
- Delay register:
  - d_act <= delay_cfg every cycle, so a new value takes effect one cycle after it appears.
  - All delay arithmetic uses d_act.
- Write, on each cycle with dinb_vld=1:
  - mem[wr_ptr] <= dinb.
  - wr_ptr <= wr_ptr+1, wrapping modulo DEPTH (15 -> 0).
  - fill_cnt <= min(fill_cnt+1, DEPTH-1).
- Read, evaluated in the same cycle as a dinb_vld=1:
  - d_act=0: doutb <= dinb (pure register, latency 1 clock, 0 samples).
  - d_act>=1: doutb <= mem[(wr_ptr - d_act) mod DEPTH], reading the pre-write contents.
  - doutb_vld <= 1 iff fill_cnt >= d_act, using the pre-increment fill_cnt.
  - Otherwise doutb_vld <= 0 and doutb holds its value.
- Idle cycles (dinb_vld=0):
  - doutb_vld <= 0; doutb, wr_ptr and fill_cnt hold.
  - Gaps therefore stretch the delay in clocks but never in samples.
- Output latency: doutb_vld is one clkb cycle after the dinb_vld that produced it.
- Output mapping: output sample n equals input sample n-D.
- Fill states, derived from fill_cnt vs d_act (no separate FSM register):
  - FILL: fill_cnt < d_act, outputs suppressed.
  - RUN: fill_cnt >= d_act.
  - After reset with D=k, the first k valid inputs produce no output; input k+1 outputs input 1.
- Delay change mid-stream:
  - Decrease: stays in RUN; the next output jumps forward, skipping (old-new) samples.
  - Increase within fill_cnt: stays in RUN; the next output repeats (new-old) earlier samples.
  - Increase beyond fill_cnt: drops to FILL until fill_cnt reaches the new D.
- Flush:
  - fill_cnt <= 0 and doutb_vld <= 0 next cycle; wr_ptr unchanged; doutb holds.
  - Flush together with dinb_vld: the sample is written and fill_cnt <= 1; no output that cycle, even if D=0.
- Saturation: fill_cnt saturating at DEPTH-1 (15) keeps D=DEPTH-1 in RUN indefinitely; no overflow or underflow flags exist.
- fill_lvl = fill_cnt.

Test Plan:
1. Reset, D=3, dinb = 1,2,3,... on consecutive valid cycles:
   - doutb_vld low for the first 3 inputs.
   - At input 4, next cycle doutb=1 with doutb_vld=1; thereafter doutb = input-3 every cycle.
2. D=0, dinb=0xA5A5A5A5 with dinb_vld=1 for one cycle:
   - Next cycle doutb=0xA5A5A5A5, doutb_vld=1.
   - Following cycle doutb_vld=0 and doutb holds.
3. D=15, stream of 40 samples 0..39:
   - First valid output is 0, at input 15.
   - Output 24 appears at input 39; wrap-around is correct and fill_lvl stays at 15.
4. D=2, stream with dinb_vld toggling 1,0,0,1,0,1,...:
   - Outputs stay exactly 2 samples behind.
   - doutb_vld only on the cycle after each valid input; doutb stable during gaps.
5. D=4 in RUN, change delay_cfg to 1 after sample 10:
   - Sample 11 (the first read with d_act=1) outputs sample 10.
   - Change back to 6: the next output repeats from sample 6 onward and stays valid (fill_cnt>=6).
6. D=3 in RUN, assert flush together with sample 20:
   - doutb_vld low for samples 20-22.
   - Sample 23 outputs 20.
   - rstb asserted with dinb_vld=1: all outputs 0 next cycle.
